hsm_gpio_driver: RTL and testbench

- Host-side initiator for the DE0 GPIO HSM handshake.
- Watches the HSM's 4-bit status code and drives its in1/in2 advance strobes to walk one complete transaction: ONE -> TWO -> THREE -> ZERO.
- Reports completion, error and a transaction count to local control logic.
- Sits on the host FPGA, with its pins wired across GPIO to the HSM controller.

---
 rtl/hsm_gpio_driver.sv | 112 +++++++++++
 tb/tb_hsm_gpio_driver.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hsm_gpio_driver.sv
// Host-side initiator for the DE0 GPIO HSM handshake: walks one ONE->TWO->THREE->ZERO transaction.
// Optional build macro HSM_DRV_AUTOCLR_EN: ERROR clears itself after TIMEOUT cycles.
`timescale 1ns/1ps
module hsm_gpio_driver #(
    parameter int unsigned TIMEOUT = 1000,
    parameter int unsigned TO_W    = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] hsm_out,
    input  logic       start,
    input  logic       err_clr,
    output logic       hsm_in1,
    output logic       hsm_in2,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    output logic [7:0] txn_count
);
    localparam logic [3:0] C_ZERO  = 4'b0000;
    localparam logic [3:0] C_ONE   = 4'b0001;
    localparam logic [3:0] C_TWO   = 4'b0010;
    localparam logic [3:0] C_THREE = 4'b0100;
    localparam logic [3:0] C_FAULT = 4'b1111;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_ONE, DRIVE1, DRIVE2, WAIT_ZERO, DONE, ERROR
    } state_t;

    state_t          state, next_state;
    logic [3:0]      sync1, s;
    logic [TO_W-1:0] to_cnt;
    logic            waiting, cnt_en, fault, timed_out;

    assign waiting = (state inside {WAIT_ONE, DRIVE1, DRIVE2, WAIT_ZERO});
`ifdef HSM_DRV_AUTOCLR_EN
    assign cnt_en = waiting || (state == ERROR);
`else
    assign cnt_en = waiting;
`endif

    always_comb begin
        next_state = state;
        fault      = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE:      if (start) next_state = WAIT_ONE;
            WAIT_ONE: begin
                if (s == C_ONE)        next_state = DRIVE1;
                else if (s == C_FAULT) fault = 1'b1;
            end
            DRIVE1: begin
                if (s == C_TWO)        next_state = DRIVE2;
                else if (s != C_ONE)   fault = 1'b1;
            end
            DRIVE2: begin
                if (s == C_THREE)      next_state = WAIT_ZERO;
                else if (s == C_ZERO)  next_state = DONE;
                else if (s != C_TWO)   fault = 1'b1;
            end
            WAIT_ZERO: begin
                if (s == C_ZERO || s == C_ONE) next_state = DONE;
                else if (s != C_THREE)         fault = 1'b1;
            end
            DONE:      next_state = IDLE;
            ERROR: begin
                if (err_clr) next_state = IDLE;
`ifdef HSM_DRV_AUTOCLR_EN
                else if (to_cnt == TO_LAST) next_state = IDLE;
`endif
            end
            default:   next_state = IDLE;
        endcase
        // An illegal code takes precedence; timeout only fires when nothing else moved the FSM.
        timed_out = waiting && !fault && (next_state == state) && (to_cnt == TO_LAST);
        if (fault || timed_out) next_state = ERROR;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sync1     <= '0;
            s         <= '0;
            to_cnt    <= '0;
            hsm_in1   <= 1'b0;
            hsm_in2   <= 1'b0;
            err_code  <= '0;
            txn_count <= '0;
        end else begin
            sync1 <= hsm_out;
            s     <= sync1;
            state <= next_state;
            // Strobes decode the next state so they rise and fall on the same edge as the FSM.
            hsm_in1 <= (next_state == DRIVE1);
            hsm_in2 <= (next_state == DRIVE2);
            if (next_state != state) to_cnt <= '0;
            else if (cnt_en)         to_cnt <= to_cnt + TO_W'(1);
            if (fault)                          err_code <= 2'b01;
            else if (timed_out)                 err_code <= 2'b10;
            else if (state == ERROR && err_clr) err_code <= '0;
            else if (state == IDLE && start)    err_code <= '0;
            if (state == DONE) txn_count <= txn_count + 8'd1;
        end
    end

    assign busy = (state inside {WAIT_ONE, DRIVE1, DRIVE2, WAIT_ZERO, DONE});
    assign done = (state == DONE);
    assign err  = (state == ERROR);

endmodule

// File: tb/tb_hsm_gpio_driver.sv
// Self-checking bench for hsm_gpio_driver: randomized HSM responder plus a rule-level reference model.
`timescale 1ns/1ps
module tb_hsm_gpio_driver;
    localparam int unsigned TO = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] hsm_out = 4'b0000;
    logic       start = 1'b0;
    logic       err_clr = 1'b0;
    logic       hsm_in1, hsm_in2, busy, done, err;
    logic [1:0] err_code;
    logic [7:0] txn_count;

    hsm_gpio_driver #(.TIMEOUT(TO), .TO_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .hsm_out(hsm_out), .start(start), .err_clr(err_clr),
        .hsm_in1(hsm_in1), .hsm_in2(hsm_in2), .busy(busy), .done(done), .err(err),
        .err_code(err_code), .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    localparam int P_IDLE = 0, P_W1 = 1, P_D1 = 2, P_D2 = 3, P_WZ = 4, P_DONE = 5, P_ERR = 6;
    localparam int M_NORMAL = 0, M_SKIP = 1, M_FAULT = 2, M_ILLEGAL = 3, M_STUCK = 4;

    int         m_phase, m_age, m_code, m_count, m_total;
    logic [3:0] m_pipe[$];
    int         h_mode = M_NORMAL;
    bit         h_arm = 1'b0;
    int         in1_cycles, done_seen, err_cycles;

    function automatic void model_reset();
        m_phase = P_IDLE;
        m_age   = 0;
        m_code  = 0;
        m_count = 0;
        m_pipe  = '{4'b0000, 4'b0000};
    endfunction

    // Reference behaviour: one call per rising edge, using the pre-edge inputs.
    function automatic void model_step();
        logic [3:0] sc;
        int nxt;
        bit bad;
        sc  = m_pipe[0];
        nxt = m_phase;
        bad = 1'b0;
        case (m_phase)
            P_IDLE: if (start) begin nxt = P_W1; m_code = 0; end
            P_W1:   if (sc == 4'b0001) nxt = P_D1; else if (sc == 4'b1111) bad = 1'b1;
            P_D1:   if (sc == 4'b0010) nxt = P_D2; else if (sc != 4'b0001) bad = 1'b1;
            P_D2:   if (sc == 4'b0100) nxt = P_WZ; else if (sc == 4'b0000) nxt = P_DONE;
                    else if (sc != 4'b0010) bad = 1'b1;
            P_WZ:   if (sc == 4'b0000 || sc == 4'b0001) nxt = P_DONE;
                    else if (sc != 4'b0100) bad = 1'b1;
            P_DONE: begin nxt = P_IDLE; m_count = (m_count + 1) % 256; m_total++; end
            P_ERR: begin
                if (err_clr) begin nxt = P_IDLE; m_code = 0; end
`ifdef HSM_DRV_AUTOCLR_EN
                else if (m_age == TO - 1) nxt = P_IDLE;
`endif
            end
            default: nxt = P_IDLE;
        endcase
        if (bad) begin
            nxt = P_ERR; m_code = 1;
        end else if (m_phase inside {[P_W1:P_WZ]} && nxt == m_phase && m_age == TO - 1) begin
            nxt = P_ERR; m_code = 2;
        end
        m_age   = (nxt == m_phase) ? m_age + 1 : 0;
        m_phase = nxt;
        void'(m_pipe.pop_front());
        m_pipe.push_back(hsm_out);
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("hsm_in1",   8'(hsm_in1),   8'(m_phase == P_D1));
        chk("hsm_in2",   8'(hsm_in2),   8'(m_phase == P_D2));
        chk("busy",      8'(busy),      8'(m_phase inside {[P_W1:P_DONE]}));
        chk("done",      8'(done),      8'(m_phase == P_DONE));
        chk("err",       8'(err),       8'(m_phase == P_ERR));
        chk("err_code",  8'(err_code),  8'(m_code));
        chk("txn_count", txn_count,     8'(m_count));
    endtask

    function automatic logic [3:0] rand_illegal();
        logic [3:0] v;
        for (int i = 0; i < 32; i++) begin
            v = 4'($urandom_range(15, 0));
            if (!(v inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1111})) return v;
        end
        return 4'b0011;
    endfunction

    // Behavioural HSM: random-latency responses to the strobes, with fault modes.
    task automatic hsm_react();
        if ($urandom_range(1, 0) == 0) return;
        case (hsm_out)
            4'b0000: if (h_arm) hsm_out = 4'b0001;
            4'b0001: if (hsm_in1 && h_mode != M_STUCK)
                         hsm_out = (h_mode == M_ILLEGAL) ? rand_illegal() : 4'b0010;
            4'b0010: if (hsm_in2) begin
                         if (h_mode == M_FAULT)     hsm_out = 4'b1111;
                         else if (h_mode == M_SKIP) begin hsm_out = 4'b0000; h_arm = 1'b0; end
                         else                       hsm_out = 4'b0100;
                     end
            4'b0100: begin hsm_out = 4'b0000; h_arm = 1'b0; end
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset_n) model_reset(); else model_step();
        @(negedge clk);
        check_all();
        if (hsm_in1) in1_cycles++;
        if (done)    done_seen++;
        if (err)     err_cycles++;
        hsm_react();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        h_arm = 1'b0; hsm_out = 4'b0000; h_mode = M_NORMAL;
        tick(); tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic run_txn(input int mode);
        int n;
        h_mode = mode; h_arm = 1'b1;
        in1_cycles = 0; done_seen = 0; err_cycles = 0;
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (m_phase != P_IDLE && m_phase != P_ERR && n < 200) begin tick(); n++; end
        checks++;
        assert (n < 200) else begin errors++; $error("FAIL txn_bound: got=%0d expected<200", n); end
    endtask

    task automatic finish_txn();
        int n;
        if (m_phase == P_ERR) begin
`ifdef HSM_DRV_AUTOCLR_EN
            n = 0;
            while (m_phase == P_ERR && n < 100) begin tick(); n++; end
            checks++;
            assert (n < 100) else begin errors++; $error("FAIL autoclr_bound: got=%0d expected<100", n); end
`else
            err_clr = 1'b1; tick(); err_clr = 1'b0;
`endif
        end
        h_arm = 1'b0; hsm_out = 4'b0000; h_mode = M_NORMAL;
        tick(); tick(); tick();
    endtask

    initial begin
        int n;
        model_reset();
        m_total = 0;

        // Reset state
        tick(); tick();
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_count", txn_count, 8'd0);
        reset_n = 1'b1;
        tick(); tick();

        // Clean transaction
        run_txn(M_NORMAL);
        chk("clean_done_pulses", 8'(done_seen), 8'd1);
        chk("clean_count", txn_count, 8'd1);
        chk("clean_busy", 8'(busy), 8'd0);
        finish_txn();

        // Stuck HSM -> timeout 16 cycles after DRIVE1 entry
        run_txn(M_STUCK);
        chk("stuck_err", 8'(err), 8'd1);
        chk("stuck_code", 8'(err_code), 8'd2);
        chk("stuck_in1", 8'(hsm_in1), 8'd0);
        chk("stuck_in1_cycles", 8'(in1_cycles), 8'(TO));
`ifdef HSM_DRV_AUTOCLR_EN
        err_cycles = 1;
        n = 0;
        while (m_phase == P_ERR && n < 100) begin tick(); n++; end
        chk("autoclr_err_cycles", 8'(err_cycles), 8'(TO));
        chk("autoclr_code_kept", 8'(err_code), 8'd2);
`endif
        finish_txn();
        chk("stuck_clr_err", 8'(err), 8'd0);
        chk("stuck_clr_busy", 8'(busy), 8'd0);

        // Fault code during DRIVE2; start in ERROR is ignored
        run_txn(M_FAULT);
        chk("fault_err", 8'(err), 8'd1);
        chk("fault_code", 8'(err_code), 8'd1);
        chk("fault_in2", 8'(hsm_in2), 8'd0);
        start = 1'b1; tick(); start = 1'b0;
        chk("fault_start_ign_err", 8'(err), 8'd1);
        chk("fault_start_ign_busy", 8'(busy), 8'd0);
        finish_txn();

        // Missed THREE
        run_txn(M_SKIP);
        chk("skip_done_pulses", 8'(done_seen), 8'd1);
        chk("skip_err", 8'(err), 8'd0);
        finish_txn();

        // Reset mid-operation while hsm_in2 is high
        h_mode = M_NORMAL; h_arm = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (m_phase != P_D2 && n < 100) begin tick(); n++; end
        chk("midrst_pre_in2", 8'(hsm_in2), 8'd1);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_in2", 8'(hsm_in2), 8'd0);
        chk("midrst_in1", 8'(hsm_in1), 8'd0);
        chk("midrst_busy", 8'(busy), 8'd0);
        chk("midrst_done", 8'(done), 8'd0);
        chk("midrst_err", 8'(err), 8'd0);
        chk("midrst_code", 8'(err_code), 8'd0);
        chk("midrst_count", txn_count, 8'd0);
        h_arm = 1'b0; hsm_out = 4'b0000;
        tick(); tick();
        reset_n = 1'b1;
        tick(); tick();
        run_txn(M_NORMAL);
        chk("postrst_count", txn_count, 8'd1);
        finish_txn();

        // err_clr and start together in ERROR
        run_txn(M_STUCK);
        err_clr = 1'b1; start = 1'b1; tick(); err_clr = 1'b0; start = 1'b0;
        chk("contend_busy", 8'(busy), 8'd0);
        chk("contend_err", 8'(err), 8'd0);
        tick();
        chk("contend_start_dropped", 8'(busy), 8'd0);
        finish_txn();

        // 256 completed transactions wrap the counter, with random error cases mixed in
        do_reset();
        m_total = 0;
        for (int i = 0; i < 1000 && m_total < 256; i++) begin
            case ($urandom_range(5, 0))
                0, 1, 2: run_txn(M_NORMAL);
                3:       run_txn(M_SKIP);
                4:       run_txn(M_FAULT);
                default: run_txn(M_ILLEGAL);
            endcase
            finish_txn();
        end
        checks++;
        assert (m_total == 256) else begin errors++; $error("FAIL wrap_bound: got=%0d expected=256", m_total); end
        chk("wrap_count", txn_count, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
